latch_write_arbiter: RTL and testbench

- Shares one bank of NLAT level-sensitive D latches, each W bits wide, among NREQ requesters.
- Each write is sequenced as: data setup, then the latch enable pulse, then data hold. Latch enables are never asserted combinationally from request inputs.
- Sits between the requester logic and the latch bank.
- Guarantees:
  - at most one latch is transparent at any time;
  - data is stable around every enable edge;
  - requesters are served fairly, by round-robin.

---
 rtl/latch_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/latch_write_arbiter.sv | 138 +++++++++++++
 tb/tb_latch_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch write arbiter.
package latch_ctrl_pkg;

  // Write sequencing states: setup, enable pulse, hold.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Width of the enable-duration counter; OPEN_CYC-1 must fit.
  localparam int CNT_W = 4;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares one latch bank among several requesters. Each write runs
// SETUP (data driven) -> OPEN (one enable high) -> HOLD (data kept, ack).
// Enables, ack and err are registered so they never glitch from request inputs.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int NLAT     = 8,
  parameter  int W        = 8,
  parameter  int OPEN_CYC = 2,
  localparam int AW       = idx_w(NLAT),
  localparam int IW       = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [NLAT-1:0]   le,
  output logic [W-1:0]      ld,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  localparam logic [AW:0]      NLAT_V  = (AW+1)'(NLAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(OPEN_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [W-1:0]      data_q, data_d;
  logic [NLAT-1:0]   le_q, le_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;

  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic [NLAT-1:0]   addr_dec;
  logic              in_range;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Decode of the captured address; an out-of-range address matches nothing.
  for (genvar gi = 0; gi < NLAT; gi++) begin : g_dec
    assign addr_dec[gi] = (addr_q == AW'(gi));
  end

  assign in_range = ({1'b0, addr_q} < NLAT_V);

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gid_d   = gnt_idx;
          addr_d  = addr[gnt_idx*AW +: AW];
          data_d  = wdata[gnt_idx*W +: W];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LD;
        state_d = OPEN;
      end
      OPEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      HOLD: begin
        ptr_d   = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the state being entered, then registered.
    le_d  = (state_d == OPEN) ? addr_dec : '0;
    ack_d = '0;
    if (state_d == HOLD) ack_d[gid_q] = 1'b1;
    err_d = (state_d == HOLD) && !in_range;
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      addr_q  <= '0;
      data_q  <= '0;
      le_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      le_q    <= le_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign le       = le_q;
  assign ld       = data_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = gid_q;

  a_le_onehot:  assert property (@(posedge clk) $onehot0(le));
  a_le_in_open: assert property (@(posedge clk) (le != '0) |-> (state_q == OPEN));
  a_ack_onehot: assert property (@(posedge clk) $onehot0(ack));
  a_ack_hold:   assert property (@(posedge clk) (ack != '0) |-> (state_q == HOLD));

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench: stimulus pushes expected writes to a scoreboard, a monitor
// pops and checks each one when an ack appears.
module tb_latch_write_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int AW   = 3;
  localparam int OPEN_CYC = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*W-1:0] wdata;

  logic [NREQ-1:0] ack8, ack6;
  logic            err8, err6;
  logic [7:0]      le8;
  logic [5:0]      le6;
  logic [7:0]      ld8, ld6;
  logic            busy8, busy6;
  logic [1:0]      gid8, gid6;

  logic            sel6;
  logic [NREQ-1:0] m_ack;
  logic            m_err;
  logic [7:0]      m_le;
  logic [7:0]      m_ld;
  logic            m_busy;
  logic [1:0]      m_gid;

  latch_write_arbiter #(.NREQ(4), .NLAT(8), .W(8), .OPEN_CYC(OPEN_CYC)) u_dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
    .ack(ack8), .err(err8), .le(le8), .ld(ld8), .busy(busy8), .grant_id(gid8)
  );

  latch_write_arbiter #(.NREQ(4), .NLAT(6), .W(8), .OPEN_CYC(OPEN_CYC)) u_dut6 (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
    .ack(ack6), .err(err6), .le(le6), .ld(ld6), .busy(busy6), .grant_id(gid6)
  );

  assign m_ack  = sel6 ? ack6  : ack8;
  assign m_err  = sel6 ? err6  : err8;
  assign m_le   = sel6 ? {2'b00, le6} : le8;
  assign m_ld   = sel6 ? ld6   : ld8;
  assign m_busy = sel6 ? busy6 : busy8;
  assign m_gid  = sel6 ? gid6  : gid8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         rid;
    logic [7:0] le;
    int         le_cyc;
    logic [7:0] data;
    logic       err;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pend[NREQ];
  bit   churn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_txn(input int rid, input logic [7:0] le, input int le_cyc,
                            input logic [7:0] data, input logic err, input int gap);
    exp_t e;
    e.rid = rid; e.le = le; e.le_cyc = le_cyc; e.data = data; e.err = err; e.gap = gap;
    sb.push_back(e);
  endtask

  // One clock: requesters drop their request once they see their ack.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack[i] && pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) req[i] = 1'b0;
      end
    end
    if (churn && m_busy) wdata[1*W +: W] = 8'($urandom);
  endtask

  task automatic issue(input int r, input int a, input logic [7:0] d, input int n);
    addr[r*AW +: AW] = AW'(a);
    wdata[r*W +: W]  = d;
    pend[r]          = n;
    req[r]           = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || req != '0 || m_busy) && n < 200) begin
      step();
      n++;
    end
    check({name, "_completes"}, 32'(n < 200), 32'd1);
    if (n >= 200) begin
      sb.delete();
      req = '0;
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
    end
    repeat (2) step();
  endtask

  // Monitor: tracks each write from SETUP to ack and checks it against the scoreboard.
  bit         mon_busy_prev = 1'b0;
  int         mon_setup_cyc = 0;
  int         mon_le_cnt    = 0;
  int         mon_last_ack  = -100;
  logic [7:0] mon_le_or     = '0;
  logic [7:0] mon_ld_cap    = '0;
  bit         mon_ld_bad    = 1'b0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (m_busy && !mon_busy_prev) begin
        mon_setup_cyc = cyc;
        mon_le_cnt    = 0;
        mon_le_or     = '0;
        mon_ld_cap    = m_ld;
        mon_ld_bad    = 1'b0;
      end
      if (m_busy) begin
        if (m_le != '0) begin
          mon_le_cnt++;
          mon_le_or = mon_le_or | m_le;
        end
        if (m_ld !== mon_ld_cap) mon_ld_bad = 1'b1;
      end
      if (m_ack != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(m_ack), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn: cycle %0d ack=%b grant=%0d ld=%h le=%h err=%b", cyc, m_ack, m_gid, mon_ld_cap, mon_le_or, m_err);
          check("ack_vector",  32'(m_ack), 32'(1 << e.rid));
          check("grant_id",    32'(m_gid), 32'(e.rid));
          check("err",         32'(m_err), 32'(e.err));
          check("ld_data",     32'(mon_ld_cap), 32'(e.data));
          check("ld_stable",   32'(mon_ld_bad), 32'd0);
          check("le_value",    32'(mon_le_or), 32'(e.le));
          check("le_cycles",   32'(mon_le_cnt), 32'(e.le_cyc));
          check("ack_latency", 32'(cyc - mon_setup_cyc), 32'(OPEN_CYC + 1));
          if (e.gap > 0) check("ack_spacing", 32'(cyc - mon_last_ack), 32'(e.gap));
        end
        mon_last_ack = cyc;
      end else if (m_err) begin
        check("err_without_ack", 32'(m_err), 32'd0);
      end
      mon_busy_prev = m_busy;
    end
  end

  initial begin : stimulus
    reset = 1'b0; req = '0; addr = '0; wdata = '0; sel6 = 1'b0; churn = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    step(); step();
    check("rst_ack",  32'(m_ack),  32'd0);
    check("rst_err",  32'(m_err),  32'd0);
    check("rst_le",   32'(m_le),   32'd0);
    check("rst_ld",   32'(m_ld),   32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_gid",  32'(m_gid),  32'd0);
    reset = 1'b1;
    step();

    // Single write to latch 3.
    issue(0, 3, 8'hA5, 1);
    expect_txn(0, 8'h08, 2, 8'hA5, 1'b0, 0);
    wait_done("t1");

    // Fresh pointer, then all four requesters at once.
    reset = 1'b0;
    step();
    check("t2_rst_ld", 32'(m_ld), 32'd0);
    reset = 1'b1;
    step();
    issue(0, 1, 8'h11, 1);
    issue(1, 2, 8'h22, 1);
    issue(2, 4, 8'h33, 1);
    issue(3, 6, 8'h44, 1);
    expect_txn(0, 8'h02, 2, 8'h11, 1'b0, 0);
    expect_txn(1, 8'h04, 2, 8'h22, 1'b0, 5);
    expect_txn(2, 8'h10, 2, 8'h33, 1'b0, 5);
    expect_txn(3, 8'h40, 2, 8'h44, 1'b0, 5);
    wait_done("t2a");
    issue(0, 0, 8'h61, 1);
    issue(3, 5, 8'h64, 1);
    expect_txn(0, 8'h01, 2, 8'h61, 1'b0, 0);
    expect_txn(3, 8'h20, 2, 8'h64, 1'b0, 5);
    wait_done("t2b");

    // Requester 2 keeps requesting while requester 1 waits: must alternate.
    issue(2, 1, 8'h77, 2);
    expect_txn(2, 8'h02, 2, 8'h77, 1'b0, 0);
    for (int n = 0; n < 10 && !m_busy; n++) step();
    issue(1, 6, 8'h88, 2);
    expect_txn(1, 8'h40, 2, 8'h88, 1'b0, 5);
    expect_txn(2, 8'h02, 2, 8'h77, 1'b0, 5);
    expect_txn(1, 8'h40, 2, 8'h88, 1'b0, 5);
    wait_done("t3");

    // Data churns after capture; latched value must not follow it.
    issue(1, 7, 8'h3C, 1);
    expect_txn(1, 8'h80, 2, 8'h3C, 1'b0, 0);
    churn = 1'b1;
    wait_done("t4");
    churn = 1'b0;

    // Reset during the second enable cycle aborts the write.
    issue(0, 2, 8'h99, 1);
    for (int n = 0; n < 10 && m_le == '0; n++) step();
    check("t5_le_open", 32'(m_le), 32'h04);
    step();
    reset = 1'b0;
    step();
    check("t5_le_abort",   32'(m_le),   32'd0);
    check("t5_busy_abort", 32'(m_busy), 32'd0);
    check("t5_ack_abort",  32'(m_ack),  32'd0);
    req = '0;
    pend[0] = 0;
    step();
    reset = 1'b1;
    repeat (3) step();
    issue(0, 4, 8'h44, 1);
    issue(3, 5, 8'h55, 1);
    expect_txn(0, 8'h10, 2, 8'h44, 1'b0, 0);
    expect_txn(3, 8'h20, 2, 8'h55, 1'b0, 5);
    wait_done("t5");

    // Six-entry bank, address 7: no enable, err with ack, same timing.
    sel6 = 1'b1;
    repeat (2) step();
    issue(0, 7, 8'h5A, 1);
    expect_txn(0, 8'h00, 0, 8'h5A, 1'b1, 0);
    wait_done("t6");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
